ex_stage_pipe: RTL and testbench
================================

Name: ex_stage_pipe

Overview:
- Execute-stage pipeline slice of the 5-stage 64-bit RISC-V CPU.
- Contains the ID/EX pipeline register, the branch-target adder (pc + imm), and the EX/MEM pipeline register.
- The ALU and its operand mux stay outside the block. The block presents the ID/EX fields to them and latches the ALU result and zero flag into EX/MEM.
- It also drives the PC-select term (branch AND zero) back to fetch.

Parameters:
- XLEN, 64, datapath width of pc, register data, immediate, ALU result and branch target.
- RA_W, 5, destination register index width.

Ports:
- Clk  in  1  single clock; all registers update on rising edge.
- Reset  in  1  asynchronous, active-high; clears every register.
- Read  in  1  pipeline load enable; 1 = both registers capture, 0 = both hold.
- id_reg_write, id_mem_to_reg, id_branch, id_mem_read, id_mem_write, id_alu_src  in  1 each  decoded controls from ID.
- id_alu_op  in  2  ALU-op class from control.
- id_pc  in  XLEN  pc of the instruction in ID.
- id_rd1, id_rd2  in  XLEN  register-file read data.
- id_imm  in  XLEN  sign-extended immediate, already in byte units (no shift applied here).
- id_funct3  in  3  instruction bits 14:12.
- id_rd  in  RA_W  instruction bits 11:7.
- ex_alu_result  in  XLEN  external ALU result for the instruction held in ID/EX.
- ex_zero  in  1  external ALU zero flag.
- ex_* outputs  out  field widths  registered ID/EX contents, one output per input field above: ex_reg_write, ex_mem_to_reg, ex_branch, ex_mem_read, ex_mem_write, ex_alu_op, ex_alu_src, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_funct3, ex_rd.
- ex_branch_target  out  XLEN  combinational ex_pc + ex_imm.
- mem_reg_write, mem_mem_to_reg, mem_branch, mem_mem_read, mem_mem_write  out  1 each  registered EX/MEM controls.
- mem_branch_target  out  XLEN  registered branch target.
- mem_zero  out  1  registered zero flag.
- mem_alu_result  out  XLEN  registered ALU result; this is the data-memory address.
- mem_store_data  out  XLEN  registered ex_rd2.
- mem_rd  out  RA_W  registered destination register.
- pc_src  out  1  mem_branch AND mem_zero; combinational from EX/MEM outputs.

Behaviour:
- Reset asserted at any time, including mid-operation: all ex_* and mem_* registers clear to 0 immediately, without waiting for a clock edge.
  - Consequently pc_src = 0 and ex_branch_target = 0 while Reset is held.
- ID/EX: on a rising Clk edge with Reset=0 and Read=1, every ex_* register takes the matching id_* input.
- EX/MEM: on the same edge, the EX/MEM registers capture:
  - the ex_ controls reg_write, mem_to_reg, branch, mem_read, mem_write;
  - ex_pc + ex_imm;
  - ex_zero;
  - ex_alu_result;
  - ex_rd2;
  - ex_rd.
- ex_alu_op, ex_alu_src and ex_funct3 are consumed in EX only and are not forwarded to EX/MEM.
- Read=0: both registers hold their values. Read gates both stages together; there is no per-stage stall.
- Latency: an id_* field appears on ex_* 1 cycle after capture and on mem_* 2 cycles after capture.
- Adder:
  - unsigned XLEN-bit sum, wraps modulo 2^XLEN;
  - no carry or overflow output;
  - negative offsets work through two's complement.
- Simultaneous Reset and clock edge: Reset wins.
- No bypass: the input-to-output path always goes through a register, except the two combinational outputs ex_branch_target and pc_src.

Optional Feature:
- Macro: EX_STAGE_PIPE_FLUSH_EN.
- With macro defined:
  - extra input flush (1 bit);
  - on a capturing edge (Read=1) with flush=1, the ID/EX control bits load 0 (reg_write, mem_to_reg, branch, mem_read, mem_write, alu_src, alu_op);
  - all ID/EX data fields load normally;
  - EX/MEM is unaffected by flush.
- Without macro: no flush port; behaviour exactly as above.

Decomposition:
- Shared package cpu_pkg holds XLEN, RA_W, and packed struct typedefs:
  - ctrl_ex_t {alu_op, alu_src};
  - ctrl_mem_t {branch, mem_read, mem_write};
  - ctrl_wb_t {reg_write, mem_to_reg}.
- One natural sub-module, pipe_reg: parameterised width, Clk/Reset/Read, async clear to 0. Instantiate it twice (ID/EX, EX/MEM).
- The adder is a single continuous assignment inside ex_stage_pipe.

Test Plan:
- Reset: assert Reset mid-cycle with registers loaded -> all ex_*, mem_* outputs and pc_src read 0 immediately, before the next edge.
- Pipeline flow: Read=1, id_pc=0x10, id_imm=0x8, id_rd2=0xDEAD, id_rd=7, id_reg_write=1 -> after 1 edge ex_branch_target=0x18; after 2 edges mem_branch_target=0x18, mem_store_data=0xDEAD, mem_rd=7, mem_reg_write=1.
- Branch taken: id_branch=1 captured, then ex_zero=1 in the EX cycle -> pc_src=1 after the second edge. Same sequence with ex_zero=0 -> pc_src=0.
- Stall: load values, then drive Read=0 and change all inputs for 3 cycles -> all outputs unchanged.
- Adder wrap and negative offset:
  - id_pc=0xFFFF_FFFF_FFFF_FFFC, id_imm=0x8 -> ex_branch_target=0x4;
  - id_pc=0x20, id_imm=-0x10 -> 0x10.
- Flush (macro on): flush=1 with id_mem_write=1, id_reg_write=1, id_rd=3 -> ex_mem_write=0, ex_reg_write=0, ex_rd=3.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths and pipeline-register field layouts for the 64-bit RISC-V core.
package cpu_pkg;

    localparam int XLEN = 64;
    localparam int RA_W = 5;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src;
    } ctrl_ex_t;

    typedef struct packed {
        logic branch;
        logic mem_read;
        logic mem_write;
    } ctrl_mem_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } ctrl_wb_t;

    typedef struct packed {
        ctrl_wb_t          wb;
        ctrl_mem_t         mem;
        ctrl_ex_t          ex;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   rd1;
        logic [XLEN-1:0]   rd2;
        logic [XLEN-1:0]   imm;
        logic [2:0]        funct3;
        logic [RA_W-1:0]   rd;
    } id_ex_t;

    typedef struct packed {
        ctrl_wb_t          wb;
        ctrl_mem_t         mem;
        logic [XLEN-1:0]   branch_target;
        logic              zero;
        logic [XLEN-1:0]   alu_result;
        logic [XLEN-1:0]   store_data;
        logic [RA_W-1:0]   rd;
    } ex_mem_t;

endpackage

// File: rtl/pipe_reg.sv
// pipe_reg: width-parameterised pipeline register with async clear and shared load enable.
module pipe_reg #(
    parameter int W = 1
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Read,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            q <= '0;
        else if (Read)
            q <= d;
    end

endmodule

// File: rtl/ex_stage_pipe.sv
// ex_stage_pipe: ID/EX and EX/MEM registers, branch-target adder and pc_src for the EX stage.
// Optional EX_STAGE_PIPE_FLUSH_EN adds a flush input that zeroes ID/EX controls on capture.
module ex_stage_pipe
    import cpu_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Read,
`ifdef EX_STAGE_PIPE_FLUSH_EN
    input  logic              flush,
`endif
    input  logic              id_reg_write,
    input  logic              id_mem_to_reg,
    input  logic              id_branch,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_alu_src,
    input  logic [1:0]        id_alu_op,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_rd1,
    input  logic [XLEN-1:0]   id_rd2,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [2:0]        id_funct3,
    input  logic [RA_W-1:0]   id_rd,
    input  logic [XLEN-1:0]   ex_alu_result,
    input  logic              ex_zero,
    output logic              ex_reg_write,
    output logic              ex_mem_to_reg,
    output logic              ex_branch,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic [1:0]        ex_alu_op,
    output logic              ex_alu_src,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_rd1,
    output logic [XLEN-1:0]   ex_rd2,
    output logic [XLEN-1:0]   ex_imm,
    output logic [2:0]        ex_funct3,
    output logic [RA_W-1:0]   ex_rd,
    output logic [XLEN-1:0]   ex_branch_target,
    output logic              mem_reg_write,
    output logic              mem_mem_to_reg,
    output logic              mem_branch,
    output logic              mem_mem_read,
    output logic              mem_mem_write,
    output logic [XLEN-1:0]   mem_branch_target,
    output logic              mem_zero,
    output logic [XLEN-1:0]   mem_alu_result,
    output logic [XLEN-1:0]   mem_store_data,
    output logic [RA_W-1:0]   mem_rd,
    output logic              pc_src
);

    id_ex_t  id_d, ex_q;
    ex_mem_t ex_d, mem_q;
    logic    kill;

`ifdef EX_STAGE_PIPE_FLUSH_EN
    assign kill = flush;
`else
    assign kill = 1'b0;
`endif

    // Flush squashes only the controls; data fields still flow so debug visibility is kept.
    always_comb begin
        id_d.wb.reg_write  = id_reg_write  & ~kill;
        id_d.wb.mem_to_reg = id_mem_to_reg & ~kill;
        id_d.mem.branch    = id_branch     & ~kill;
        id_d.mem.mem_read  = id_mem_read   & ~kill;
        id_d.mem.mem_write = id_mem_write  & ~kill;
        id_d.ex.alu_op     = kill ? 2'b00 : id_alu_op;
        id_d.ex.alu_src    = id_alu_src    & ~kill;
        id_d.pc            = id_pc;
        id_d.rd1           = id_rd1;
        id_d.rd2           = id_rd2;
        id_d.imm           = id_imm;
        id_d.funct3        = id_funct3;
        id_d.rd            = id_rd;
    end

    pipe_reg #(.W($bits(id_ex_t))) u_id_ex (
        .Clk   (Clk),
        .Reset (Reset),
        .Read  (Read),
        .d     (id_d),
        .q     (ex_q)
    );

    assign ex_reg_write     = ex_q.wb.reg_write;
    assign ex_mem_to_reg    = ex_q.wb.mem_to_reg;
    assign ex_branch        = ex_q.mem.branch;
    assign ex_mem_read      = ex_q.mem.mem_read;
    assign ex_mem_write     = ex_q.mem.mem_write;
    assign ex_alu_op        = ex_q.ex.alu_op;
    assign ex_alu_src       = ex_q.ex.alu_src;
    assign ex_pc            = ex_q.pc;
    assign ex_rd1           = ex_q.rd1;
    assign ex_rd2           = ex_q.rd2;
    assign ex_imm           = ex_q.imm;
    assign ex_funct3        = ex_q.funct3;
    assign ex_rd            = ex_q.rd;
    assign ex_branch_target = ex_q.pc + ex_q.imm;

    always_comb begin
        ex_d.wb            = ex_q.wb;
        ex_d.mem           = ex_q.mem;
        ex_d.branch_target = ex_branch_target;
        ex_d.zero          = ex_zero;
        ex_d.alu_result    = ex_alu_result;
        ex_d.store_data    = ex_q.rd2;
        ex_d.rd            = ex_q.rd;
    end

    pipe_reg #(.W($bits(ex_mem_t))) u_ex_mem (
        .Clk   (Clk),
        .Reset (Reset),
        .Read  (Read),
        .d     (ex_d),
        .q     (mem_q)
    );

    assign mem_reg_write     = mem_q.wb.reg_write;
    assign mem_mem_to_reg    = mem_q.wb.mem_to_reg;
    assign mem_branch        = mem_q.mem.branch;
    assign mem_mem_read      = mem_q.mem.mem_read;
    assign mem_mem_write     = mem_q.mem.mem_write;
    assign mem_branch_target = mem_q.branch_target;
    assign mem_zero          = mem_q.zero;
    assign mem_alu_result    = mem_q.alu_result;
    assign mem_store_data    = mem_q.store_data;
    assign mem_rd            = mem_q.rd;
    assign pc_src            = mem_q.mem.branch & mem_q.zero;

endmodule

// File: tb/tb_ex_stage_pipe.sv
// tb_ex_stage_pipe: directed-vector bench for ex_stage_pipe (flush test when EX_STAGE_PIPE_FLUSH_EN is set).
module tb_ex_stage_pipe;

    logic        Clk = 0, Reset, Read;
    logic        id_reg_write, id_mem_to_reg, id_branch, id_mem_read, id_mem_write, id_alu_src;
    logic [1:0]  id_alu_op;
    logic [63:0] id_pc, id_rd1, id_rd2, id_imm, ex_alu_result;
    logic [2:0]  id_funct3;
    logic [4:0]  id_rd;
    logic        ex_zero;
    logic        ex_reg_write, ex_mem_to_reg, ex_branch, ex_mem_read, ex_mem_write, ex_alu_src;
    logic [1:0]  ex_alu_op;
    logic [63:0] ex_pc, ex_rd1, ex_rd2, ex_imm, ex_branch_target;
    logic [2:0]  ex_funct3;
    logic [4:0]  ex_rd;
    logic        mem_reg_write, mem_mem_to_reg, mem_branch, mem_mem_read, mem_mem_write, mem_zero, pc_src;
    logic [63:0] mem_branch_target, mem_alu_result, mem_store_data;
    logic [4:0]  mem_rd;
`ifdef EX_STAGE_PIPE_FLUSH_EN
    logic        flush = 0;
`endif
    int pass = 0, total = 0;

    always #5 Clk = ~Clk;

    ex_stage_pipe dut (
        .Clk(Clk), .Reset(Reset), .Read(Read),
`ifdef EX_STAGE_PIPE_FLUSH_EN
        .flush(flush),
`endif
        .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_alu_src(id_alu_src),
        .id_alu_op(id_alu_op), .id_pc(id_pc), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_funct3(id_funct3), .id_rd(id_rd), .ex_alu_result(ex_alu_result), .ex_zero(ex_zero),
        .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_alu_op(ex_alu_op),
        .ex_alu_src(ex_alu_src), .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
        .ex_funct3(ex_funct3), .ex_rd(ex_rd), .ex_branch_target(ex_branch_target),
        .mem_reg_write(mem_reg_write), .mem_mem_to_reg(mem_mem_to_reg), .mem_branch(mem_branch),
        .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
        .mem_branch_target(mem_branch_target), .mem_zero(mem_zero), .mem_alu_result(mem_alu_result),
        .mem_store_data(mem_store_data), .mem_rd(mem_rd), .pc_src(pc_src)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_inputs();
        {id_reg_write, id_mem_to_reg, id_branch, id_mem_read, id_mem_write, id_alu_src} = '0;
        id_alu_op = 0; id_pc = 0; id_rd1 = 0; id_rd2 = 0; id_imm = 0;
        id_funct3 = 0; id_rd = 0; ex_alu_result = 0; ex_zero = 0;
    endtask

    task automatic test_reset();
        Reset = 1; Read = 1; clear_inputs();
        tick(); tick();
        Reset = 0;
        total++; if (ex_pc !== 64'h0 || mem_rd !== 5'h0 || pc_src !== 1'b0)
            $display("FAIL reset_init: ex_pc=%h mem_rd=%h pc_src=%b want 0", ex_pc, mem_rd, pc_src); else pass++;
        id_pc = 64'h40; id_imm = 64'h4; id_rd = 5'd11; id_branch = 1; id_reg_write = 1;
        tick();
        ex_zero = 1; ex_alu_result = 64'h77;
        tick();
        total++; if (pc_src !== 1'b1 || mem_rd !== 5'd11 || ex_pc !== 64'h40)
            $display("FAIL reset_preload: pc_src=%b mem_rd=%h ex_pc=%h want 1/0b/40", pc_src, mem_rd, ex_pc); else pass++;
        #2 Reset = 1;
        #1;
        total++; if ({ex_reg_write, ex_branch, ex_pc, ex_imm, ex_rd, ex_branch_target} !== '0)
            $display("FAIL reset_async_ex: ex_pc=%h ex_imm=%h ex_rd=%h bt=%h want 0", ex_pc, ex_imm, ex_rd, ex_branch_target); else pass++;
        total++; if ({mem_reg_write, mem_branch, mem_zero, mem_rd, mem_alu_result, mem_branch_target, pc_src} !== '0)
            $display("FAIL reset_async_mem: mem_rd=%h alu=%h bt=%h pc_src=%b want 0", mem_rd, mem_alu_result, mem_branch_target, pc_src); else pass++;
        tick();
        total++; if (ex_pc !== 64'h0 || mem_alu_result !== 64'h0 || pc_src !== 1'b0)
            $display("FAIL reset_wins_edge: ex_pc=%h alu=%h pc_src=%b want 0", ex_pc, mem_alu_result, pc_src); else pass++;
        #2 Reset = 0;
        clear_inputs();
        tick();
    endtask

    task automatic test_flow();
        clear_inputs(); Read = 1;
        id_pc = 64'h10; id_imm = 64'h8; id_rd2 = 64'hDEAD; id_rd = 5'd7; id_reg_write = 1;
        tick();
        total++; if (ex_branch_target !== 64'h18 || ex_rd !== 5'd7 || ex_rd2 !== 64'hDEAD || ex_reg_write !== 1'b1)
            $display("FAIL flow_ex: bt=%h rd=%h rd2=%h rw=%b want 18/07/dead/1", ex_branch_target, ex_rd, ex_rd2, ex_reg_write); else pass++;
        total++; if (mem_rd !== 5'd0 || mem_reg_write !== 1'b0)
            $display("FAIL flow_no_bypass: mem_rd=%h mem_rw=%b want 0/0", mem_rd, mem_reg_write); else pass++;
        clear_inputs(); ex_alu_result = 64'h1234;
        tick();
        total++; if (mem_branch_target !== 64'h18 || mem_store_data !== 64'hDEAD || mem_rd !== 5'd7 || mem_reg_write !== 1'b1)
            $display("FAIL flow_mem: bt=%h sd=%h rd=%h rw=%b want 18/dead/07/1", mem_branch_target, mem_store_data, mem_rd, mem_reg_write); else pass++;
        total++; if (mem_alu_result !== 64'h1234 || ex_rd !== 5'd0)
            $display("FAIL flow_alu: alu=%h ex_rd=%h want 1234/00", mem_alu_result, ex_rd); else pass++;
    endtask

    task automatic test_branch();
        clear_inputs(); Read = 1;
        id_branch = 1;
        tick();
        id_branch = 0; ex_zero = 1;
        tick();
        total++; if (pc_src !== 1'b1 || mem_branch !== 1'b1 || mem_zero !== 1'b1)
            $display("FAIL branch_taken: pc_src=%b br=%b z=%b want 1/1/1", pc_src, mem_branch, mem_zero); else pass++;
        id_branch = 1; ex_zero = 0;
        tick();
        id_branch = 0; ex_zero = 0;
        tick();
        total++; if (pc_src !== 1'b0 || mem_branch !== 1'b1 || mem_zero !== 1'b0)
            $display("FAIL branch_not_taken: pc_src=%b br=%b z=%b want 0/1/0", pc_src, mem_branch, mem_zero); else pass++;
        ex_zero = 1;
        tick();
        total++; if (pc_src !== 1'b0 || mem_branch !== 1'b0)
            $display("FAIL branch_zero_only: pc_src=%b br=%b want 0/0", pc_src, mem_branch); else pass++;
    endtask

    task automatic test_stall();
        clear_inputs(); Read = 1;
        id_pc = 64'h100; id_rd1 = 64'hAAAA; id_rd2 = 64'hBBBB; id_imm = 64'h40;
        id_funct3 = 3'd5; id_rd = 5'd9; id_alu_op = 2'd2; id_alu_src = 1; id_mem_write = 1;
        tick();
        ex_alu_result = 64'h5555; ex_zero = 1;
        tick();
        Read = 0;
        for (int i = 0; i < 3; i++) begin
            id_pc = 64'h900 + i; id_rd1 = 64'h1; id_rd2 = 64'h2; id_imm = 64'h3;
            id_funct3 = 3'd1; id_rd = 5'd30; id_alu_op = 2'd1; id_alu_src = 0; id_mem_write = 0;
            id_reg_write = 1; id_branch = 1; ex_alu_result = 64'hF0F0 + i; ex_zero = 0;
            tick();
        end
        total++; if (ex_pc !== 64'h100 || ex_rd1 !== 64'hAAAA || ex_funct3 !== 3'd5 || ex_alu_op !== 2'd2 || ex_alu_src !== 1'b1 || ex_reg_write !== 1'b0)
            $display("FAIL stall_ex: pc=%h rd1=%h f3=%h op=%h src=%b rw=%b want 100/aaaa/5/2/1/0", ex_pc, ex_rd1, ex_funct3, ex_alu_op, ex_alu_src, ex_reg_write); else pass++;
        total++; if (ex_branch_target !== 64'h140 || mem_branch_target !== 64'h140)
            $display("FAIL stall_bt: ex_bt=%h mem_bt=%h want 140/140", ex_branch_target, mem_branch_target); else pass++;
        total++; if (mem_alu_result !== 64'h5555 || mem_store_data !== 64'hBBBB || mem_rd !== 5'd9 || mem_mem_write !== 1'b1 || mem_zero !== 1'b1 || mem_branch !== 1'b0)
            $display("FAIL stall_mem: alu=%h sd=%h rd=%h mw=%b z=%b br=%b want 5555/bbbb/09/1/1/0", mem_alu_result, mem_store_data, mem_rd, mem_mem_write, mem_zero, mem_branch); else pass++;
        Read = 1;
    endtask

    task automatic test_adder();
        clear_inputs(); Read = 1;
        id_pc = 64'hFFFF_FFFF_FFFF_FFFC; id_imm = 64'h8;
        tick();
        total++; if (ex_branch_target !== 64'h4)
            $display("FAIL adder_wrap: got %h want 0000000000000004", ex_branch_target); else pass++;
        id_pc = 64'h20; id_imm = -64'sd16;
        tick();
        total++; if (ex_branch_target !== 64'h10)
            $display("FAIL adder_neg: got %h want 0000000000000010", ex_branch_target); else pass++;
        total++; if (mem_branch_target !== 64'h4)
            $display("FAIL adder_wrap_mem: got %h want 0000000000000004", mem_branch_target); else pass++;
    endtask

    task automatic test_back_to_back();
        clear_inputs(); Read = 1;
        id_rd = 5'd1; id_mem_read = 1; id_mem_to_reg = 1;
        tick();
        id_rd = 5'd2; id_mem_read = 0; id_mem_to_reg = 0;
        tick();
        total++; if (mem_rd !== 5'd1 || mem_mem_read !== 1'b1 || mem_mem_to_reg !== 1'b1 || ex_rd !== 5'd2)
            $display("FAIL b2b_first: mem_rd=%h mr=%b m2r=%b ex_rd=%h want 01/1/1/02", mem_rd, mem_mem_read, mem_mem_to_reg, ex_rd); else pass++;
        id_rd = 5'd3;
        tick();
        total++; if (mem_rd !== 5'd2 || mem_mem_read !== 1'b0 || ex_rd !== 5'd3)
            $display("FAIL b2b_second: mem_rd=%h mr=%b ex_rd=%h want 02/0/03", mem_rd, mem_mem_read, ex_rd); else pass++;
    endtask

`ifdef EX_STAGE_PIPE_FLUSH_EN
    task automatic test_flush();
        clear_inputs(); Read = 1;
        id_reg_write = 1; id_mem_write = 1; id_rd = 5'd3; id_alu_op = 2'd3; id_pc = 64'h80;
        tick();
        flush = 1;
        tick();
        total++; if (ex_mem_write !== 1'b0 || ex_reg_write !== 1'b0 || ex_alu_op !== 2'd0 || ex_rd !== 5'd3 || ex_pc !== 64'h80)
            $display("FAIL flush_ex: mw=%b rw=%b op=%h rd=%h pc=%h want 0/0/0/03/80", ex_mem_write, ex_reg_write, ex_alu_op, ex_rd, ex_pc); else pass++;
        total++; if (mem_mem_write !== 1'b1 || mem_reg_write !== 1'b1)
            $display("FAIL flush_mem_kept: mw=%b rw=%b want 1/1", mem_mem_write, mem_reg_write); else pass++;
        flush = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_flow();
        test_branch();
        test_stall();
        test_adder();
        test_back_to_back();
`ifdef EX_STAGE_PIPE_FLUSH_EN
        test_flush();
`endif
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
